// File: rtl/axi_mem_responder_pkg.sv
// Shared types and encodings for the AXI4 memory responder.
// Holds the AXI request/response bundles, resp/burst codes and FSM states.
package axi_mem_responder_pkg;

    localparam int AXI_ADDR_W  = 16;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_IDW_W   = 4;
    localparam int AXI_IDR_W   = 4;
    localparam int AXI_STRB_W  = AXI_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ
    } state_t;

    typedef struct packed {
        logic [AXI_IDW_W-1:0]  aw_id;
        logic [AXI_ADDR_W-1:0] aw_addr;
        logic [7:0]            aw_len;
        logic [2:0]            aw_size;
        logic [1:0]            aw_burst;
        logic                  aw_valid;
        logic [AXI_DATA_W-1:0] w_data;
        logic [AXI_STRB_W-1:0] w_strb;
        logic                  w_last;
        logic                  w_valid;
        logic                  b_ready;
        logic [AXI_IDR_W-1:0]  ar_id;
        logic [AXI_ADDR_W-1:0] ar_addr;
        logic [7:0]            ar_len;
        logic [2:0]            ar_size;
        logic [1:0]            ar_burst;
        logic                  ar_valid;
        logic                  r_ready;
    } axi_mosi_t;

    typedef struct packed {
        logic                  aw_ready;
        logic                  w_ready;
        logic [AXI_IDW_W-1:0]  b_id;
        logic [1:0]            b_resp;
        logic                  b_valid;
        logic                  ar_ready;
        logic [AXI_IDR_W-1:0]  r_id;
        logic [AXI_DATA_W-1:0] r_data;
        logic [1:0]            r_resp;
        logic                  r_last;
        logic                  r_valid;
    } axi_miso_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Word memory for the AXI responder: byte-enabled write,
// combinational read, contents deliberately left unreset.
module axi_mem_responder_ram
    import axi_mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int IDX_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wstrb,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Byte-lane write of the selected word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave endpoint serving one burst at a time from local memory.
// Optional PMU counters are built when AXI_RESP_PMU_EN is defined.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic      ACLK,
    input  logic      ARESETn,
    input  axi_mosi_t s_axi_i,
    output axi_miso_t s_axi_o
`ifdef AXI_RESP_PMU_EN
    ,
    output logic [31:0] pmu_wr_bursts_o,
    output logic [31:0] pmu_rd_bursts_o,
    output logic [31:0] pmu_err_o
`endif
);

    localparam int OFF   = clog2(DATA_WIDTH / 8);
    localparam int IDX_W = clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [2:0] SIZE_L = 3'(OFF);

    state_t state_q, state_d;

    logic                  rr_last_write_q;
    logic [ID_W_WIDTH-1:0] bid_q;
    logic [ID_R_WIDTH-1:0] rid_q;
    logic [7:0]            len_q;
    logic                  fixed_q;
    logic                  bad_q;
    logic                  lo_q;
    logic                  dec_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic [8:0]            cnt_q;
    logic [1:0]            bresp_q;

    logic grant_w, grant_r;
    logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic beat_oor, in_len, at_len, mem_we;
    logic [ADDR_WIDTH-1:0] ax_addr;
    logic [ADDR_WIDTH:0]   ax_diff;
    logic [7:0]            ax_len;
    logic [2:0]            ax_size;
    logic [1:0]            ax_burst;
    logic [1:0]            r_resp;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Fair write/read grant, flipped by whichever was served last
    assign grant_w = s_axi_i.aw_valid &&
                     (!s_axi_i.ar_valid || !rr_last_write_q);
    assign grant_r = s_axi_i.ar_valid &&
                     (!s_axi_i.aw_valid || rr_last_write_q);

    assign aw_hs = (state_q == ST_IDLE) && grant_w;
    assign ar_hs = (state_q == ST_IDLE) && grant_r;
    assign w_hs  = (state_q == ST_WRITE) && s_axi_i.w_valid;
    assign b_hs  = (state_q == ST_WRESP) && s_axi_i.b_ready;
    assign r_hs  = (state_q == ST_READ) && s_axi_i.r_ready;

    assign ax_addr  = grant_w ? s_axi_i.aw_addr  : s_axi_i.ar_addr;
    assign ax_len   = grant_w ? s_axi_i.aw_len   : s_axi_i.ar_len;
    assign ax_size  = grant_w ? s_axi_i.aw_size  : s_axi_i.ar_size;
    assign ax_burst = grant_w ? s_axi_i.aw_burst : s_axi_i.ar_burst;
    // Extra top bit is the borrow: set when the address sits below the base
    assign ax_diff  = {1'b0, ax_addr} - {1'b0, BASE_ADDR};

    assign beat_oor = lo_q || (idx_q >= DEPTH_L);
    assign in_len   = cnt_q <= {1'b0, len_q};
    assign at_len   = cnt_q == {1'b0, len_q};
    assign mem_we   = w_hs && !beat_oor && in_len && !bad_q;
    assign r_resp   = beat_oor ? RESP_DECERR :
                      bad_q    ? RESP_SLVERR : RESP_OKAY;

    axi_mem_responder_ram #(
        .DEPTH (MEM_DEPTH),
        .DW    (DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (ACLK),
        .we    (mem_we),
        .addr  (idx_q[IDX_W-1:0]),
        .wdata (s_axi_i.w_data),
        .wstrb (s_axi_i.w_strb),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (aw_hs)      state_d = ST_WRITE;
                else if (ar_hs) state_d = ST_READ;
            end
            ST_WRITE: if (w_hs && s_axi_i.w_last) state_d = ST_WRESP;
            ST_WRESP: if (b_hs) state_d = ST_IDLE;
            ST_READ:  if (r_hs && at_len) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Channel outputs decoded from state and the latched burst context
    always_comb begin
        s_axi_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                s_axi_o.aw_ready = grant_w;
                s_axi_o.ar_ready = grant_r;
            end
            ST_WRITE: s_axi_o.w_ready = 1'b1;
            ST_WRESP: begin
                s_axi_o.b_valid = 1'b1;
                s_axi_o.b_id    = bid_q;
                s_axi_o.b_resp  = bresp_q;
            end
            ST_READ: begin
                s_axi_o.r_valid = 1'b1;
                s_axi_o.r_id    = rid_q;
                s_axi_o.r_data  = (beat_oor || bad_q) ? '0 : ram_rdata;
                s_axi_o.r_resp  = r_resp;
                s_axi_o.r_last  = at_len;
            end
            default: ;
        endcase
    end

    // Burst context capture and per-beat index/counter advance
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_last_write_q <= 1'b0;
            bid_q           <= '0;
            rid_q           <= '0;
            len_q           <= '0;
            fixed_q         <= 1'b0;
            bad_q           <= 1'b0;
            lo_q            <= 1'b0;
            dec_q           <= 1'b0;
            idx_q           <= '0;
            cnt_q           <= '0;
            bresp_q         <= RESP_OKAY;
        end else if (aw_hs || ar_hs) begin
            rr_last_write_q <= aw_hs;
            if (aw_hs) bid_q <= s_axi_i.aw_id;
            else       rid_q <= s_axi_i.ar_id;
            len_q   <= ax_len;
            fixed_q <= ax_burst == BURST_FIXED;
            bad_q   <= ax_burst[1] || (ax_size != SIZE_L);
            lo_q    <= ax_diff[ADDR_WIDTH];
            idx_q   <= {1'b0, ax_diff[ADDR_WIDTH-1:0] >> OFF};
            cnt_q   <= '0;
            dec_q   <= 1'b0;
        end else if (w_hs || r_hs) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            // Index stops once it overflows so it stays out of range
            if (!fixed_q && !idx_q[ADDR_WIDTH]) idx_q <= idx_q + 1'b1;
            if (beat_oor && in_len) dec_q <= 1'b1;
            if (w_hs && s_axi_i.w_last) begin
                if (dec_q || (beat_oor && in_len))
                    bresp_q <= RESP_DECERR;
                else if (bad_q || !at_len)
                    bresp_q <= RESP_SLVERR;
                else
                    bresp_q <= RESP_OKAY;
            end
        end
    end

`ifdef AXI_RESP_PMU_EN
    // Saturating burst and error counters
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pmu_wr_bursts_o <= '0;
            pmu_rd_bursts_o <= '0;
            pmu_err_o       <= '0;
        end else begin
            if (b_hs && pmu_wr_bursts_o != '1)
                pmu_wr_bursts_o <= pmu_wr_bursts_o + 1'b1;
            if (r_hs && at_len && pmu_rd_bursts_o != '1)
                pmu_rd_bursts_o <= pmu_rd_bursts_o + 1'b1;
            if (((b_hs && bresp_q != RESP_OKAY) ||
                 (r_hs && r_resp != RESP_OKAY)) && pmu_err_o != '1)
                pmu_err_o <= pmu_err_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: vector table of bursts
// plus hand sequences for stalls, reset and arbitration.
module tb_axi_mem_responder;
    import axi_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    axi_mosi_t s_i;
    axi_miso_t s_o;
`ifdef AXI_RESP_PMU_EN
    logic [31:0] pmu_wr, pmu_rd, pmu_err;
`endif

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .s_axi_i (s_i),
        .s_axi_o (s_o)
`ifdef AXI_RESP_PMU_EN
        ,
        .pmu_wr_bursts_o (pmu_wr),
        .pmu_rd_bursts_o (pmu_rd),
        .pmu_err_o       (pmu_err)
`endif
    );

    always @(negedge clk) if (s_o.aw_ready && s_o.ar_ready) overlap++;

    typedef struct packed {
        bit              wr;
        logic [3:0]      id;
        logic [15:0]     addr;
        logic [7:0]      len;
        logic [1:0]      burst;
        logic [2:0]      size;
        int              nb;
        logic [3:0][31:0] d;
        logic [3:0]      strb;
        logic [3:0][1:0] resp;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic vec_t mk(input bit wr, input logic [3:0] id,
                                input logic [15:0] addr, input logic [7:0] len,
                                input logic [1:0] burst, input logic [2:0] size,
                                input int nb, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] d3, input logic [3:0] strb,
                                input logic [1:0] r0, input logic [1:0] r1);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len;
        v.burst = burst; v.size = size; v.nb = nb;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.strb = strb;
        v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r1; v.resp[3] = r1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [15:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input int nb,
                            input logic [3:0][31:0] d, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [3:0] bid);
        int n;
        s_i.aw_id = id; s_i.aw_addr = addr; s_i.aw_len = len;
        s_i.aw_burst = burst; s_i.aw_size = size; s_i.aw_valid = 1'b1;
        #1;
        n = 0;
        while (!s_o.aw_ready && n < 20) begin tick; n++; end
        chk("aw_ready", 64'(s_o.aw_ready), 64'(1));
        tick;
        s_i.aw_valid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            s_i.w_data = d[i]; s_i.w_strb = strb;
            s_i.w_last = (i == nb - 1); s_i.w_valid = 1'b1;
            #1;
            n = 0;
            while (!s_o.w_ready && n < 20) begin tick; n++; end
            tick;
        end
        s_i.w_valid = 1'b0; s_i.w_last = 1'b0;
        #1;
        chk("b_valid_first", 64'(s_o.b_valid), 64'(1));
        n = 0;
        while (!s_o.b_valid && n < 20) begin tick; n++; end
        resp = s_o.b_resp; bid = s_o.b_id;
        s_i.b_ready = 1'b1;
        tick;
        s_i.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size,
                           output logic [3:0][31:0] d, output logic [3:0][1:0] resp,
                           output logic [3:0] last, output logic [3:0][3:0] rid,
                           output int nb);
        int n;
        bit done;
        d = '0; resp = '0; last = '0; rid = '0;
        s_i.ar_id = id; s_i.ar_addr = addr; s_i.ar_len = len;
        s_i.ar_burst = burst; s_i.ar_size = size; s_i.ar_valid = 1'b1;
        #1;
        n = 0;
        while (!s_o.ar_ready && n < 20) begin tick; n++; end
        chk("ar_ready", 64'(s_o.ar_ready), 64'(1));
        tick;
        s_i.ar_valid = 1'b0;
        s_i.r_ready = 1'b1;
        #1;
        chk("r_valid_first", 64'(s_o.r_valid), 64'(1));
        nb = 0; done = 1'b0;
        while (!done && nb < 4) begin
            n = 0;
            while (!s_o.r_valid && n < 20) begin tick; n++; end
            if (!s_o.r_valid) begin
                chk("r_valid_timeout", 64'(0), 64'(1));
                break;
            end
            d[nb] = s_o.r_data; resp[nb] = s_o.r_resp;
            last[nb] = s_o.r_last; rid[nb] = s_o.r_id;
            done = s_o.r_last; nb++;
            tick;
        end
        s_i.r_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] resp;
        logic [3:0] bid;
        logic [3:0][31:0] rd;
        logic [3:0][1:0] rr;
        logic [3:0] rl;
        logic [3:0][3:0] rids;
        int nb, n;
        bit got_w;

        vt[0]  = mk(1, 4'h3, 16'h0010, 0, BURST_INCR, 2, 1, 32'hDEADBEEF, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[1]  = mk(0, 4'h5, 16'h0010, 0, BURST_INCR, 2, 1, 32'hDEADBEEF, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[2]  = mk(1, 4'h1, 16'h0000, 3, BURST_INCR, 2, 4, 1, 2, 3, 4, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[3]  = mk(0, 4'h2, 16'h0000, 3, BURST_INCR, 2, 4, 1, 2, 3, 4, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[4]  = mk(1, 4'h4, 16'h0020, 0, BURST_INCR, 2, 1, 32'hFFFFFFFF, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[5]  = mk(1, 4'h4, 16'h0020, 0, BURST_INCR, 2, 1, 32'h00000000, 0, 0, 0, 4'h5, RESP_OKAY, RESP_OKAY);
        vt[6]  = mk(0, 4'h6, 16'h0020, 0, BURST_INCR, 2, 1, 32'hFF00FF00, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[7]  = mk(0, 4'h7, 16'h0400, 0, BURST_INCR, 2, 1, 0, 0, 0, 0, 4'hF, RESP_DECERR, RESP_DECERR);
        vt[8]  = mk(1, 4'h8, 16'h0030, 0, BURST_INCR, 2, 1, 32'hAAAA5555, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[9]  = mk(1, 4'h9, 16'h0030, 0, BURST_WRAP, 2, 1, 32'h12345678, 0, 0, 0, 4'hF, RESP_SLVERR, RESP_SLVERR);
        vt[10] = mk(0, 4'hA, 16'h0030, 0, BURST_INCR, 2, 1, 32'hAAAA5555, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[11] = mk(1, 4'hB, 16'h0040, 3, BURST_INCR, 2, 3, 32'h11, 32'h22, 32'h33, 0, 4'hF, RESP_SLVERR, RESP_SLVERR);
        vt[12] = mk(0, 4'hC, 16'h0040, 1, BURST_INCR, 2, 2, 32'h11, 32'h22, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[13] = mk(0, 4'hD, 16'h0000, 0, BURST_INCR, 1, 1, 0, 0, 0, 0, 4'hF, RESP_SLVERR, RESP_SLVERR);
        vt[14] = mk(1, 4'hE, 16'h0050, 1, BURST_FIXED, 2, 2, 7, 9, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[15] = mk(0, 4'hF, 16'h0050, 0, BURST_INCR, 2, 1, 9, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[16] = mk(1, 4'h1, 16'h03FC, 0, BURST_INCR, 2, 1, 32'hCAFEF00D, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[17] = mk(0, 4'h2, 16'h03FC, 1, BURST_INCR, 2, 2, 32'hCAFEF00D, 0, 0, 0, 4'hF, RESP_OKAY, RESP_DECERR);
        vt[18] = mk(1, 4'h3, 16'h03FC, 1, BURST_INCR, 2, 2, 1, 2, 0, 0, 4'hF, RESP_DECERR, RESP_DECERR);
        vt[19] = mk(0, 4'h4, 16'h03FC, 0, BURST_INCR, 2, 1, 1, 0, 0, 0, 4'hF, RESP_OKAY, RESP_OKAY);
        vt[20] = mk(1, 4'h5, 16'h0060, 0, BURST_INCR, 2, 2, 32'h55, 32'h66, 0, 0, 4'hF, RESP_SLVERR, RESP_SLVERR);

        s_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(s_o), 64'(0));
        rst_n = 1'b1;
        tick;
        chk("idle_no_ready", 64'({s_o.aw_ready, s_o.ar_ready}), 64'(0));

        for (int v = 0; v < NV; v++) begin
            if (vt[v].wr) begin
                do_write(vt[v].id, vt[v].addr, vt[v].len, vt[v].burst,
                         vt[v].size, vt[v].nb, vt[v].d, vt[v].strb, resp, bid);
                chk($sformatf("v%0d bresp", v), 64'(resp), 64'(vt[v].resp[0]));
                chk($sformatf("v%0d bid", v), 64'(bid), 64'(vt[v].id));
            end else begin
                do_read(vt[v].id, vt[v].addr, vt[v].len, vt[v].burst,
                        vt[v].size, rd, rr, rl, rids, nb);
                chk($sformatf("v%0d beats", v), 64'(nb), 64'(vt[v].nb));
                for (int b = 0; b < vt[v].nb; b++) begin
                    chk($sformatf("v%0d b%0d rdata", v, b), 64'(rd[b]), 64'(vt[v].d[b]));
                    chk($sformatf("v%0d b%0d rresp", v, b), 64'(rr[b]), 64'(vt[v].resp[b]));
                    chk($sformatf("v%0d b%0d rlast", v, b), 64'(rl[b]), 64'(b == vt[v].nb - 1));
                    chk($sformatf("v%0d b%0d rid", v, b), 64'(rids[b]), 64'(vt[v].id));
                end
            end
        end

        s_i.ar_id = 4'h9; s_i.ar_addr = 16'h0000; s_i.ar_len = 8'd3;
        s_i.ar_burst = BURST_INCR; s_i.ar_size = 3'd2; s_i.ar_valid = 1'b1;
        #1;
        n = 0;
        while (!s_o.ar_ready && n < 20) begin tick; n++; end
        tick;
        s_i.ar_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_i.r_ready = 1'b0;
            #1;
            chk($sformatf("stall%0d rdata", b), 64'(s_o.r_data), 64'(b + 1));
            chk($sformatf("stall%0d rid", b), 64'(s_o.r_id), 64'(9));
            tick;
            chk($sformatf("held%0d rdata", b), 64'(s_o.r_data), 64'(b + 1));
            chk($sformatf("held%0d rid", b), 64'(s_o.r_id), 64'(9));
            chk($sformatf("held%0d rlast", b), 64'(s_o.r_last), 64'(b == 3));
            s_i.r_ready = 1'b1;
            tick;
        end
        s_i.r_ready = 1'b0;
        #1;
        chk("stall_burst_done", 64'(s_o.r_valid), 64'(0));

        s_i.ar_id = 4'h6; s_i.ar_addr = 16'h0000; s_i.ar_len = 8'd3;
        s_i.ar_valid = 1'b1;
        #1;
        n = 0;
        while (!s_o.ar_ready && n < 20) begin tick; n++; end
        tick;
        s_i.ar_valid = 1'b0;
        s_i.r_ready = 1'b1;
        tick;
        s_i.r_ready = 1'b0;
        #1;
        chk("mid_burst_valid", 64'(s_o.r_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(s_o), 64'(0));
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_reset_outputs", 64'(s_o), 64'(0));
`ifdef AXI_RESP_PMU_EN
        chk("pmu_wr_reset", 64'(pmu_wr), 64'(0));
        chk("pmu_rd_reset", 64'(pmu_rd), 64'(0));
        chk("pmu_err_reset", 64'(pmu_err), 64'(0));
`endif
        do_read(4'h3, 16'h0010, 0, BURST_INCR, 2, rd, rr, rl, rids, nb);
        chk("post_reset_rdata", 64'(rd[0]), 64'(32'hDEADBEEF));
        chk("post_reset_rresp", 64'(rr[0]), 64'(RESP_OKAY));

        for (int k = 0; k < 4; k++) begin
            s_i.aw_id = 4'h1; s_i.aw_addr = 16'h0070; s_i.aw_len = 8'd0;
            s_i.aw_burst = BURST_INCR; s_i.aw_size = 3'd2;
            s_i.ar_id = 4'h2; s_i.ar_addr = 16'h0070; s_i.ar_len = 8'd0;
            s_i.ar_burst = BURST_INCR; s_i.ar_size = 3'd2;
            s_i.aw_valid = 1'b1; s_i.ar_valid = 1'b1;
            #1;
            n = 0;
            while (!(s_o.aw_ready || s_o.ar_ready) && n < 20) begin tick; n++; end
            got_w = s_o.aw_ready;
            chk($sformatf("arb%0d grant_w", k), 64'(got_w), 64'(k % 2 == 0));
            chk($sformatf("arb%0d both_ready", k),
                64'(s_o.aw_ready && s_o.ar_ready), 64'(0));
            tick;
            s_i.aw_valid = 1'b0; s_i.ar_valid = 1'b0;
            if (got_w) begin
                s_i.w_data = 32'(k); s_i.w_strb = 4'hF;
                s_i.w_last = 1'b1; s_i.w_valid = 1'b1;
                tick;
                s_i.w_valid = 1'b0; s_i.w_last = 1'b0;
                #1;
                n = 0;
                while (!s_o.b_valid && n < 20) begin tick; n++; end
                s_i.b_ready = 1'b1;
                tick;
                s_i.b_ready = 1'b0;
            end else begin
                s_i.r_ready = 1'b1;
                #1;
                n = 0;
                while (!s_o.r_valid && n < 20) begin tick; n++; end
                tick;
                s_i.r_ready = 1'b0;
            end
        end
        tick;
        chk("aw_ar_overlap", 64'(overlap), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
